// File: rtl/i2s_receiver.sv
// I2S ADC deserialiser: synchronises the codec serial lines into CLK and
// delivers sign-extended left/right sample pairs with a one-cycle strobe.
module i2s_receiver #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  audio_ready,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } state_t;

    state_t state, state_next;

    logic bclk_s1, bclk_s2, bclk_s3;
    logic lr_s1, lr_s2;
    logic sd_s1, sd_s2;
    logic rise, lr_now, sd_now, lr_prev, lr_edge;

    logic [SAMPLE_BITS-2:0] shreg;
    logic [SAMPLE_BITS-1:0] word;
    logic [SAMPLE_BITS-1:0] hold;
    logic [CNT_W-1:0]       count;
    logic                   chan;
    logic                   left_valid;

    logic start_word, shift_en, word_done, err;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lr_s1   <= lrclk;
            lr_s2   <= lr_s1;
            sd_s1   <= sdata;
            sd_s2   <= sd_s1;
        end
    end

    assign rise    = bclk_s2 & ~bclk_s3;
    assign lr_now  = lr_s2;
    assign sd_now  = sd_s2;
    assign lr_edge = lr_now ^ lr_prev;

    // The final bit joins the word combinationally so the output load lands on
    // the same edge that sees the LSB rise.
    assign word = {shreg, sd_now};

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_word = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        err        = 1'b0;
        if (rise) begin
            case (state)
                HUNT: begin
                    if (lr_prev && !lr_now) begin
                        state_next = SHIFT;
                        start_word = 1'b1;
                    end
                end
                SHIFT: begin
                    // A channel change before the word is full is a truncation;
                    // that rise doubles as the delay slot of the new channel.
                    if (lr_edge) begin
                        err        = 1'b1;
                        start_word = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (count == CNT_W'(SAMPLE_BITS - 1)) begin
                            word_done  = 1'b1;
                            state_next = PAD;
                        end
                    end
                end
                PAD: begin
                    if (lr_edge) begin
                        state_next = SHIFT;
                        start_word = 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            lr_prev      <= 1'b0;
            shreg        <= '0;
            hold         <= '0;
            count        <= '0;
            chan         <= 1'b0;
            left_valid   <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            audio_ready  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            audio_ready <= 1'b0;
            frame_err   <= err;
            if (rise) begin
                lr_prev <= lr_now;
            end
            if (start_word) begin
                count <= '0;
                chan  <= lr_now;
            end
            if (shift_en) begin
                shreg <= word[SAMPLE_BITS-2:0];
                count <= count + CNT_W'(1);
            end
            if (err) begin
                left_valid <= 1'b0;
            end
            if (word_done) begin
                if (!chan) begin
                    hold       <= word;
                    left_valid <= 1'b1;
                end else begin
                    if (left_valid) begin
                        left_sample  <= DATA_WIDTH'($signed(hold));
                        right_sample <= DATA_WIDTH'($signed(word));
                        audio_ready  <= 1'b1;
                    end
                    left_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives an I2S stream into a 24-bit and a 16-bit
// instance and checks them against a word-level model of the framing rules.
module tb_i2s_receiver;

    localparam int HALF = 50;

    logic        CLK   = 1'b0;
    logic        rst   = 1'b0;
    logic        bclk  = 1'b0;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic [31:0] l24, r24, l16, r16;
    logic        ar24, fe24, ar16, fe16;

    always #5 CLK = ~CLK;

    i2s_receiver #(.DATA_WIDTH(32), .SAMPLE_BITS(24)) dut (
        .CLK(CLK), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .left_sample(l24), .right_sample(r24), .audio_ready(ar24), .frame_err(fe24)
    );

    i2s_receiver #(.DATA_WIDTH(32), .SAMPLE_BITS(16)) dut16 (
        .CLK(CLK), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .left_sample(l16), .right_sample(r16), .audio_ready(ar16), .frame_err(fe16)
    );

    int errors = 0;
    int checks = 0;

    int          sb[2] = '{24, 16};
    bit          hunting[2];
    bit          last_ch[2];
    bit          lv[2];
    logic [31:0] hold_m[2];
    logic [31:0] last_l[2];
    logic [31:0] last_r[2];
    int          exp_err[2];
    int          err_seen[2];
    time         t_lsb[2];
    logic [63:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        if (v >= (32'd1 << (n - 1))) return v + (32'hFFFF_FFFF << n);
        return v;
    endfunction

    // One call per channel slot: what the slot means for a receiver of k's width.
    task automatic model_slot(input int k, input bit ch, input int ndata, input logic [31:0] bits);
        logic [31:0] w;
        w = bits >> (32 - sb[k]);
        if (hunting[k]) begin
            if (ch == 1'b0 && last_ch[k] == 1'b1) begin
                hunting[k] = 1'b0;
            end else begin
                last_ch[k] = ch;
                return;
            end
        end
        last_ch[k] = ch;
        if (ndata < sb[k]) begin
            exp_err[k]++;
            lv[k] = 1'b0;
        end else if (!ch) begin
            hold_m[k] = w;
            lv[k]     = 1'b1;
        end else begin
            if (lv[k]) begin
                last_l[k] = sext(hold_m[k], sb[k]);
                last_r[k] = sext(w, sb[k]);
                if (k == 0) exp_q0.push_back({last_l[k], last_r[k]});
                else        exp_q1.push_back({last_l[k], last_r[k]});
            end
            lv[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hunting[k] = 1'b1;
            last_ch[k] = 1'b0;
            lv[k]      = 1'b0;
            last_l[k]  = '0;
            last_r[k]  = '0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_l24", l24, 0);
        check("rst_r24", r24, 0);
        check("rst_ar24", ar24, 0);
        check("rst_fe24", fe24, 0);
        check("rst_l16", l16, 0);
        check("rst_r16", r16, 0);
    endtask

    // Slot of nrises bclk rises: rise 0 is the delay slot, then bits[31] downward.
    task automatic send_slot(input bit ch, input logic [31:0] bits, input int nrises,
                             input int rst_on, input int rst_off);
        for (int i = 0; i < nrises; i++) begin
            lrclk = ch;
            if (i >= 1 && i <= 32) sdata = bits[32 - i];
            else                   sdata = 1'($urandom_range(0, 1));
            if (i == rst_on) begin
                rst = 1'b0;
                #1;
                check_reset_outputs();
                #(HALF - 1);
            end else if (i == rst_off) begin
                rst = 1'b1;
                #HALF;
            end else begin
                #HALF;
            end
            bclk = 1'b1;
            if (ch && i == 24) t_lsb[0] = $time;
            if (ch && i == 16) t_lsb[1] = $time;
            #HALF;
            bclk = 1'b0;
        end
        if (rst_on >= 0) begin
            model_reset();
            if (rst_off >= 0 && rst_off < nrises)
                for (int k = 0; k < 2; k++) model_slot(k, ch, 0, '0);
        end else begin
            for (int k = 0; k < 2; k++) model_slot(k, ch, nrises - 1, bits);
        end
    endtask

    task automatic compare_frame(input string tag);
        logic [63:0] e;
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            if (obs_q0.size() > 0) check({tag, "_pair24"}, obs_q0.pop_front(), e);
            else                   check({tag, "_missing24"}, 64'd0, e);
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            if (obs_q1.size() > 0) check({tag, "_pair16"}, obs_q1.pop_front(), e);
            else                   check({tag, "_missing16"}, 64'd0, e);
        end
        check({tag, "_extra24"}, 64'(obs_q0.size()), 0);
        check({tag, "_extra16"}, 64'(obs_q1.size()), 0);
        obs_q0 = {};
        obs_q1 = {};
        check({tag, "_l24"}, l24, last_l[0]);
        check({tag, "_r24"}, r24, last_r[0]);
        check({tag, "_l16"}, l16, last_l[1]);
        check({tag, "_r16"}, r16, last_r[1]);
        check({tag, "_err24"}, 64'(err_seen[0]), 64'(exp_err[0]));
        check({tag, "_err16"}, 64'(err_seen[1]), 64'(exp_err[1]));
    endtask

    task automatic send_frame(input string tag, input logic [31:0] l, input logic [31:0] r);
        send_slot(1'b0, l, 32, -1, -1);
        send_slot(1'b1, r, 32, -1, -1);
        compare_frame(tag);
    endtask

    // Strobe monitor; a bclk rise at t is registered in sync1 at t+3, so the
    // load edge is t+23 and the following falling CLK edge is t+28.
    always @(negedge CLK) begin
        if (ar24) begin
            obs_q0.push_back({l24, r24});
            check("lat24", 64'($time - t_lsb[0]), 28);
        end
        if (ar16) begin
            obs_q1.push_back({l16, r16});
            check("lat16", 64'($time - t_lsb[1]), 28);
        end
        if (fe24) err_seen[0]++;
        if (fe16) err_seen[1]++;
        if (ar24 || fe24) check("excl24", 64'(ar24 & fe24), 0);
        if (ar16 || fe16) check("excl16", 64'(ar16 & fe16), 0);
    end

    initial begin
        logic [31:0] a, b;
        int          n;
        model_reset();
        #3;
        check_reset_outputs();
        #19;
        rst = 1'b1;

        send_slot(1'b1, $urandom, 32, -1, -1);
        compare_frame("prime");

        send_frame("basic", {24'h123456, 8'($urandom)}, {24'hABCDEF, 8'($urandom)});
        check("basic_left", l24, 32'h00123456);
        check("basic_right", r24, 32'hFFABCDEF);

        send_frame("bb1", {24'h000001, 8'($urandom)}, {24'h7FFFFF, 8'($urandom)});
        check("bb1_left", l24, 32'h00000001);
        check("bb1_right", r24, 32'h007FFFFF);
        send_frame("bb2", {24'h800000, 8'($urandom)}, {24'h000000, 8'($urandom)});
        check("bb2_left", l24, 32'hFF800000);
        check("bb2_right", r24, 32'h00000000);
        send_frame("bb3", {24'hFFFFFF, 8'($urandom)}, {24'h400000, 8'($urandom)});
        check("bb3_left", l24, 32'hFFFFFFFF);
        check("bb3_right", r24, 32'h00400000);

        send_slot(1'b0, $urandom, 11, -1, -1);
        send_slot(1'b1, $urandom, 32, -1, -1);
        compare_frame("short");
        check("short_hold_left", l24, 32'hFFFFFFFF);
        send_frame("after_short", $urandom, $urandom);

        send_frame("w16", {16'h8001, 16'($urandom)}, {16'h7FFE, 16'($urandom)});
        check("w16_left", l16, 32'hFFFF8001);
        check("w16_right", r16, 32'h00007FFE);

        send_slot(1'b0, $urandom, 32, 12, 20);
        send_slot(1'b1, $urandom, 32, -1, -1);
        compare_frame("rst_left");
        send_frame("after_rst_left", $urandom, $urandom);

        send_slot(1'b0, $urandom, 32, -1, -1);
        send_slot(1'b1, $urandom, 32, 3, 8);
        compare_frame("rst_right");
        send_frame("after_rst_right", $urandom, $urandom);

        for (int f = 0; f < 12; f++) begin
            a = $urandom;
            b = $urandom;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 31)) : 32;
            if ($urandom_range(0, 1) == 0) begin
                send_slot(1'b0, a, n, -1, -1);
                send_slot(1'b1, b, 32, -1, -1);
            end else begin
                send_slot(1'b0, a, 32, -1, -1);
                send_slot(1'b1, b, n, -1, -1);
            end
            compare_frame("rand");
        end
        send_frame("final", $urandom, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Upstream front end of the effects chain: deserialises the codec's I2S ADC stream (bclk, lrclk, sdata) into parallel signed left/right samples.
- Issues a one-CLK `audio_ready` strobe per completed stereo frame.
- Outputs feed the effect stages (distortion etc.) directly as `x`/`audio_ready`.
- Codec serial signals are asynchronous to CLK and are synchronised inside the block.

Parameters:
- DATA_WIDTH, 32, width of output sample words.
- SAMPLE_BITS, 24, bits per channel captured from the serial stream (legal range 8..DATA_WIDTH).

Ports:
- CLK  input  1  system clock; must be ≥ 8× bclk frequency.
- rst  input  1  asynchronous, active-low reset.
- bclk  input  1  codec bit clock (async).
- lrclk  input  1  codec word select, 0 = left, 1 = right (async).
- sdata  input  1  codec ADC serial data, MSB first (async).
- left_sample  output  DATA_WIDTH  last complete left sample, sign-extended.
- right_sample  output  DATA_WIDTH  last complete right sample, sign-extended.
- audio_ready  output  1  one-CLK pulse: new left/right pair valid.
- frame_err  output  1  one-CLK pulse: channel word truncated by an early lrclk change.

Behaviour:
- Reset (rst = 0, async):
  - left_sample, right_sample, audio_ready and frame_err are all 0.
  - Synchronisers, shift register, bit counter and left holding register are cleared.
  - FSM goes to HUNT.
- Synchronisation:
  - bclk, lrclk and sdata each pass through 2 flops.
  - A third bclk flop provides rising-edge detect: a bclk rise is detected when sync2 = 1 and sync3 = 0.
  - All capture actions occur only on detected bclk rises.
- Each detected rise samples sync'd lrclk (lr_now) and sdata. lr_prev holds lr_now from the previous rise.
- I2S framing: the rise on which lr_now ≠ lr_prev is the one-bit delay slot and its data is discarded. The next SAMPLE_BITS rises carry data MSB first.
- FSM states:
  - HUNT: waits for a rise with lr_prev = 1 and lr_now = 0 (start of left). Then goes to SHIFT with channel = left and count = 0. Any right-channel data seen in HUNT is discarded.
  - SHIFT: shifts sdata into the shift register and increments count.
    - When count reaches SAMPLE_BITS, the word is complete.
    - Left complete: store in left holding register, set left_valid.
    - Right complete: if left_valid, update outputs (see next item); in all cases clear left_valid.
    - Then go to PAD.
  - PAD: ignores further bits. On a rise with lr_now ≠ lr_prev, go to SHIFT with count = 0 and channel = lr_now.
- Output update on right-complete with left_valid set, all at the same CLK edge:
  - left_sample ← holding register; right_sample ← new word.
  - audio_ready = 1 for exactly one CLK.
- Latency: the output update and audio_ready pulse occur on the CLK edge exactly 2 cycles after the CLK edge that first registers bclk high in sync1 (for the right-channel LSB rise). The final bit must therefore be concatenated combinationally into the output load.
- Width rule: the SAMPLE_BITS word is sign-extended (MSB replicated) to DATA_WIDTH.
- Outputs hold their values between updates. Bits beyond SAMPLE_BITS (e.g. 32-bit slots) are ignored.
- Boundary conditions:
  - Early lrclk change in SHIFT (count < SAMPLE_BITS): discard the partial word and pulse frame_err for one CLK. Clear left_valid if the truncated word was left or right. Treat the rise as a delay slot and restart SHIFT for the new channel.
  - Right word completes with left_valid = 0: no output update, no audio_ready.
  - Reset mid-frame: immediate clear. After release, capture resumes only at the next right→left transition.
- audio_ready and frame_err are never asserted on the same cycle.

Test Plan:
- Frame capture: 64-bclk frames, left = 24'h123456, right = 24'hABCDEF → left_sample = 32'h00123456, right_sample = 32'hFFABCDEF; audio_ready high exactly 1 CLK, 2 CLK after right LSB rise is sampled.
- Back-to-back: 3 frames (L/R = 24'h000001/24'h7FFFFF, 24'h800000/24'h000000, 24'hFFFFFF/24'h400000) → 3 audio_ready pulses with matching values. Check 32'hFF800000 and 32'hFFFFFFFF sign extension; bits 25..32 of each slot ignored.
- Short word: lrclk toggles after 10 left bits → frame_err single pulse; no audio_ready that frame; outputs keep previous frame values; next full frame captured normally.
- Start mid-right: release reset during right channel → that right word and the following left/right pair are captured normally only after the first left boundary; no audio_ready before the first complete L+R pair.
- Reset mid-operation: assert rst while shifting left bit 12 → all outputs 0 asynchronously; after release, the next full frame yields the correct pair.
- SAMPLE_BITS = 16, DATA_WIDTH = 32: left 16'h8001 → 32'hFFFF8001; right 16'h7FFE → 32'h00007FFE.
